// File: rtl/cic_pkg.sv
// Types and constants shared by the CIC output pacer and its FIFO.
package cic_pkg;

  typedef enum logic [1:0] {
    PACER_IDLE,
    PACER_PREFILL,
    PACER_RUN
  } pacer_state_e;

  localparam int UFLOW_CNT_W = 16;

endpackage

// File: rtl/cic_sync_fifo.sv
// Single-clock sample FIFO with an explicit occupancy counter.
module cic_sync_fifo
  import cic_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic signed [DATA_WIDTH-1:0] din_i,
  output logic signed [DATA_WIDTH-1:0] head_o,
  output logic [$clog2(DEPTH):0]       level_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage carries no reset; validity is defined by the pointers and level.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/cic_dac_pacer.sv
// Rate-pacing buffer between the CIC interpolator and a non-stallable DAC:
// prefill, fixed-rate drain, underflow recovery and a saturating underflow counter.
module cic_dac_pacer
  import cic_pkg::*;
#(
  parameter int DATA_WIDTH     = 24,
  parameter int DEPTH          = 16,
  parameter int RATE_DIV       = 4,
  parameter int PREFILL        = 8,
  parameter int UNDERFLOW_ZERO = 1
) (
  input  logic                         in_clock,
  input  logic                         in_reset_n,
  input  logic                         in_enable,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         dac_strobe,
  output logic signed [DATA_WIDTH-1:0] dac_data,
  output logic                         underflow_pulse,
  output logic [UFLOW_CNT_W-1:0]       underflow_count,
  output logic [$clog2(DEPTH):0]       fill_level,
  output logic                         running
);

  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int TICK_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("cic_dac_pacer: DEPTH must be a power of two and >= 4");
  end
  if (RATE_DIV < 1) begin : g_bad_rate
    $error("cic_dac_pacer: RATE_DIV must be >= 1");
  end
  if ((PREFILL < 1) || (PREFILL > DEPTH)) begin : g_bad_prefill
    $error("cic_dac_pacer: PREFILL must be within 1..DEPTH");
  end

  function automatic logic [UFLOW_CNT_W-1:0] sat_inc(input logic [UFLOW_CNT_W-1:0] v);
    return (&v) ? v : v + UFLOW_CNT_W'(1);
  endfunction

  pacer_state_e                 state_q, state_d;
  logic [TICK_W-1:0]            tick_cnt_q, tick_cnt_d;
  logic signed [DATA_WIDTH-1:0] dac_data_q, dac_data_d;
  logic                         strobe_q, strobe_d;
  logic                         uflow_pulse_q, uflow_pulse_d;
  logic [UFLOW_CNT_W-1:0]       uflow_cnt_q, uflow_cnt_d;

  logic                         push, pop;
  logic signed [DATA_WIDTH-1:0] head;
  logic [LVL_W-1:0]             level;
  logic                         full, empty;

  // A same-cycle pop never frees a slot for the push: ready looks only at occupancy.
  assign in_ready = !full;
  assign push     = in_valid && !full;

  cic_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk_i  (in_clock),
    .rst_ni (in_reset_n),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (in_data),
    .head_o (head),
    .level_o(level),
    .full_o (full),
    .empty_o(empty)
  );

  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    dac_data_d    = dac_data_q;
    strobe_d      = 1'b0;
    uflow_pulse_d = 1'b0;
    uflow_cnt_d   = uflow_cnt_q;
    pop           = 1'b0;
    if (!in_enable) begin
      state_d = PACER_IDLE;
    end else begin
      case (state_q)
        PACER_IDLE: state_d = PACER_PREFILL;
        PACER_PREFILL: begin
          if (level >= LVL_W'(PREFILL)) begin
            state_d    = PACER_RUN;
            tick_cnt_d = '0;
          end
        end
        PACER_RUN: begin
          if (tick_cnt_q == TICK_W'(RATE_DIV - 1)) begin
            tick_cnt_d = '0;
            strobe_d   = 1'b1;
            if (!empty) begin
              pop        = 1'b1;
              dac_data_d = head;
            end else begin
              // Underflow: the DAC still gets its strobe, then we rebuild the prefill margin.
              uflow_pulse_d = 1'b1;
              uflow_cnt_d   = sat_inc(uflow_cnt_q);
              if (UNDERFLOW_ZERO != 0) dac_data_d = '0;
              state_d = PACER_PREFILL;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
        default: state_d = PACER_IDLE;
      endcase
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q       <= PACER_IDLE;
      tick_cnt_q    <= '0;
      dac_data_q    <= '0;
      strobe_q      <= 1'b0;
      uflow_pulse_q <= 1'b0;
      uflow_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      dac_data_q    <= dac_data_d;
      strobe_q      <= strobe_d;
      uflow_pulse_q <= uflow_pulse_d;
      uflow_cnt_q   <= uflow_cnt_d;
    end
  end

  assign dac_strobe      = strobe_q;
  assign dac_data        = dac_data_q;
  assign underflow_pulse = uflow_pulse_q;
  assign underflow_count = uflow_cnt_q;
  assign fill_level      = level;
  assign running         = (state_q == PACER_RUN);

endmodule

// File: tb/tb_cic_dac_pacer.sv
// Scoreboard bench for cic_dac_pacer: accepted samples are queued and checked on each DAC strobe.
module tb_cic_dac_pacer;

  localparam int DW = 24;

  logic                 in_clock = 1'b0;
  logic                 in_reset_n;
  logic                 in_enable;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;

  logic                 in_ready, dac_strobe, underflow_pulse, running;
  logic signed [DW-1:0] dac_data;
  logic [15:0]          underflow_count;
  logic [4:0]           fill_level;

  logic                 h_ready, h_strobe, h_pulse, h_running;
  logic signed [DW-1:0] h_data;
  logic [15:0]          h_count;
  logic [4:0]           h_level;

  int n_checks = 0;
  int n_fail   = 0;
  logic signed [DW-1:0] sb[$];

  always #5 in_clock = ~in_clock;

  cic_dac_pacer u_dut (
    .in_clock(in_clock), .in_reset_n(in_reset_n), .in_enable(in_enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dac_strobe(dac_strobe), .dac_data(dac_data), .underflow_pulse(underflow_pulse),
    .underflow_count(underflow_count), .fill_level(fill_level), .running(running)
  );

  cic_dac_pacer #(.UNDERFLOW_ZERO(0)) u_hold (
    .in_clock(in_clock), .in_reset_n(in_reset_n), .in_enable(in_enable),
    .in_valid(in_valid), .in_ready(h_ready), .in_data(in_data),
    .dac_strobe(h_strobe), .dac_data(h_data), .underflow_pulse(h_pulse),
    .underflow_count(h_count), .fill_level(h_level), .running(h_running)
  );

  // Drive one cycle of upstream traffic; an accepted sample becomes an expected DAC value.
  task automatic drive_cycle(input bit v, input logic signed [DW-1:0] d, output bit acc);
    in_valid = v;
    in_data  = d;
    acc      = v && in_ready;
    if (acc) sb.push_back(d);
    @(negedge in_clock);
  endtask

  task automatic test_reset();
    in_reset_n = 1'b0; in_enable = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge in_clock);
    n_checks++; if (dac_data !== '0) begin n_fail++; $display("FAIL rst_dac_data: got %0d expected 0", dac_data); end
    n_checks++; if ({dac_strobe, underflow_pulse, running} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b expected 000", {dac_strobe, underflow_pulse, running}); end
    n_checks++; if (underflow_count !== 16'd0) begin n_fail++; $display("FAIL rst_uflow_count: got %0d expected 0", underflow_count); end
    n_checks++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL rst_fill_level: got %0d expected 0", fill_level); end
    in_reset_n = 1'b1;
    @(negedge in_clock);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_prefill_drain();
    bit acc;
    int nstr;
    logic signed [DW-1:0] exp;
    nstr = 0;
    in_enable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      drive_cycle(i < 8, DW'(i + 1), acc);
      if (i == 7) begin
        n_checks++; if (fill_level !== 5'd8) begin n_fail++; $display("FAIL prefill_level: got %0d expected 8", fill_level); end
      end
      if (i == 8) begin
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL enter_run: got %b expected 1", running); end
      end
      if (dac_strobe) begin
        n_checks++; if (i != 12 + 4 * nstr) begin n_fail++; $display("FAIL strobe_time: got cycle %0d expected %0d", i, 12 + 4 * nstr); end
        if (nstr < 8) begin
          n_checks++; if (underflow_pulse !== 1'b0) begin n_fail++; $display("FAIL early_uflow: got %b expected 0", underflow_pulse); end
          if (sb.size() == 0) begin
            n_checks++; n_fail++; $display("FAIL drain_extra: got strobe expected none");
          end else begin
            exp = sb.pop_front();
            n_checks++; if (dac_data !== exp) begin n_fail++; $display("FAIL drain_data: got %0d expected %0d", dac_data, exp); end
          end
        end else begin
          n_checks++; if (underflow_pulse !== 1'b1) begin n_fail++; $display("FAIL uflow_pulse: got %b expected 1", underflow_pulse); end
          n_checks++; if (dac_data !== '0) begin n_fail++; $display("FAIL uflow_zero: got %0d expected 0", dac_data); end
          n_checks++; if (h_data !== 24'sd8) begin n_fail++; $display("FAIL uflow_hold: got %0d expected 8", h_data); end
          n_checks++; if (h_strobe !== 1'b1) begin n_fail++; $display("FAIL uflow_hold_strobe: got %b expected 1", h_strobe); end
          n_checks++; if (underflow_count !== 16'd1) begin n_fail++; $display("FAIL uflow_count: got %0d expected 1", underflow_count); end
        end
        nstr++;
      end
    end
    n_checks++; if (nstr != 9) begin n_fail++; $display("FAIL strobe_total: got %0d expected 9", nstr); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL back_to_prefill: got %b expected 0", running); end
  endtask

  task automatic test_backpressure();
    bit acc;
    int nacc, nstr;
    nacc = 0; nstr = 0;
    in_enable = 1'b0;
    drive_cycle(1'b0, '0, acc);
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, DW'(100 + i), acc);
      if (acc) nacc++;
      if (dac_strobe) nstr++;
    end
    n_checks++; if (nacc != 16) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 16", nacc); end
    n_checks++; if (fill_level !== 5'd16) begin n_fail++; $display("FAIL bp_level: got %0d expected 16", fill_level); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b expected 0", in_ready); end
    n_checks++; if (nstr != 0) begin n_fail++; $display("FAIL bp_strobes: got %0d expected 0", nstr); end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int nstr, nv;
    logic signed [DW-1:0] exp;
    nstr = 0; nv = 116;
    in_enable = 1'b1;
    for (int i = 0; i < 4200; i++) begin
      drive_cycle(1'b1, DW'(nv), acc);
      if (acc) nv++;
      n_checks++; if (fill_level > 5'd16) begin n_fail++; $display("FAIL b2b_level: got %0d expected <= 16", fill_level); end
      if (fill_level == 5'd16) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b expected 0", in_ready); end
      end
      if (dac_strobe) begin
        nstr++;
        n_checks++; if (underflow_pulse !== 1'b0) begin n_fail++; $display("FAIL b2b_uflow: got %b expected 0", underflow_pulse); end
        if (sb.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL b2b_extra: got strobe expected none");
        end else begin
          exp = sb.pop_front();
          n_checks++; if (dac_data !== exp) begin n_fail++; $display("FAIL b2b_data: got %0d expected %0d", dac_data, exp); end
        end
      end
    end
    n_checks++; if (nstr < 1000) begin n_fail++; $display("FAIL b2b_ticks: got %0d expected >= 1000", nstr); end
    n_checks++; if (underflow_count !== 16'd1) begin n_fail++; $display("FAIL b2b_uflow_count: got %0d expected 1", underflow_count); end
  endtask

  task automatic test_reset_midrun();
    bit acc, found;
    logic signed [DW-1:0] exp;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      drive_cycle(1'b0, '0, acc);
      if (dac_strobe && sb.size() != 0) begin
        exp = sb.pop_front();
        n_checks++; if (dac_data !== exp) begin n_fail++; $display("FAIL mid_data: got %0d expected %0d", dac_data, exp); end
      end
      if (running && fill_level == 5'd5) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL mid_reach_level5: got timeout expected level 5 in RUN"); end
    #2 in_reset_n = 1'b0;
    #1;
    n_checks++; if (dac_data !== '0 || h_data !== '0) begin n_fail++; $display("FAIL async_dac_data: got %0d/%0d expected 0", dac_data, h_data); end
    n_checks++; if ({dac_strobe, underflow_pulse, running} !== 3'b000) begin n_fail++; $display("FAIL async_flags: got %b expected 000", {dac_strobe, underflow_pulse, running}); end
    n_checks++; if (underflow_count !== 16'd0) begin n_fail++; $display("FAIL async_uflow_count: got %0d expected 0", underflow_count); end
    n_checks++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL async_level: got %0d expected 0", fill_level); end
    sb.delete();
    in_enable = 1'b0;
    @(negedge in_clock);
    in_reset_n = 1'b1;
    drive_cycle(1'b0, '0, acc);
    n_checks++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL post_rst_level: got %0d expected 0", fill_level); end
    n_checks++; if (in_ready !== 1'b1 || running !== 1'b0) begin n_fail++; $display("FAIL post_rst_ctrl: got ready=%b run=%b expected 1/0", in_ready, running); end
  endtask

  task automatic test_uflow_saturate();
    bit acc, found;
    logic [15:0] exp_cnt;
    logic signed [DW-1:0] exp;
    // Preload the counter near its ceiling rather than simulating ~65k underflows.
    force u_dut.uflow_cnt_q = 16'hFFFD;
    @(negedge in_clock);
    release u_dut.uflow_cnt_q;
    @(negedge in_clock);
    n_checks++; if (underflow_count !== 16'hFFFD) begin n_fail++; $display("FAIL sat_preload: got %h expected fffd", underflow_count); end
    in_enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_cnt = (k == 0) ? 16'hFFFE : 16'hFFFF;
      for (int j = 0; j < 8; j++) drive_cycle(1'b1, DW'(200 + 8 * k + j), acc);
      found = 1'b0;
      for (int i = 0; i < 80; i++) begin
        drive_cycle(1'b0, '0, acc);
        if (dac_strobe) begin
          if (underflow_pulse) begin
            n_checks++; if (underflow_count !== exp_cnt) begin n_fail++; $display("FAIL sat_count: got %h expected %h", underflow_count, exp_cnt); end
            found = 1'b1;
            break;
          end else if (sb.size() != 0) begin
            exp = sb.pop_front();
            n_checks++; if (dac_data !== exp) begin n_fail++; $display("FAIL sat_data: got %0d expected %0d", dac_data, exp); end
          end
        end
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL sat_uflow_seen: got timeout expected underflow"); end
    end
    in_enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_prefill_drain();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    test_uflow_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_dac_pacer.md
# cic_dac_pacer

Rate-pacing output buffer placed directly downstream of the CIC interpolator. It accepts interpolated samples over a ready/valid stream that back-pressures the interpolator, and stores them in a small FIFO. It then drains them on a fixed-rate tick to a non-stallable sink such as a DAC. The block also provides prefill, underflow detection/recovery, and status counters.

## Interface
- DATA_WIDTH, 24, sample width (signed); matches interpolator OUT_WIDTH
- DEPTH, 16, FIFO depth; power of two, ≥ 4
- RATE_DIV, 4, clocks per output tick; ≥ 1
- PREFILL, 8, fill level required before draining starts; 1..DEPTH
- UNDERFLOW_ZERO, 1, on underflow: 1 = emit zero, 0 = repeat last sample
- in_clock  input  1  system clock
- in_reset_n  input  1  reset; asynchronous, active-low
- in_enable  input  1  run request; low forces IDLE
- in_valid  input  1  upstream sample valid
- in_ready  output  1  FIFO can accept a sample
- in_data  input  DATA_WIDTH  upstream sample (signed)
- dac_strobe  output  1  one-cycle pulse per output tick
- dac_data  output  DATA_WIDTH  registered sample to DAC
- underflow_pulse  output  1  one-cycle pulse per underflow tick
- underflow_count  output  16  saturating underflow counter
- fill_level  output  $clog2(DEPTH)+1  current FIFO occupancy
- running  output  1  high while state is RUN

## Operation
- Reset is in_reset_n, asynchronous, active-low; clock is in_clock.
- Reset values: state IDLE; dac_data 0; dac_strobe 0; underflow_pulse 0; underflow_count 0; fill_level 0; running 0. in_ready is 1 once reset deasserts.
- Parameter violations raise $error at elaboration: DEPTH not a power of two or < 4, RATE_DIV < 1, PREFILL outside 1..DEPTH.
- Write side is active in all states:
  - in_ready = (fill_level < DEPTH), computed from current occupancy only.
  - A pop in the same cycle does not free a slot for a push, so a full FIFO never accepts a write.
  - Push occurs when in_valid && in_ready.
- FSM states IDLE, PREFILL, RUN:
  - IDLE → PREFILL when in_enable = 1.
  - PREFILL → RUN when fill_level ≥ PREFILL (level sampled before this cycle's push); tick counter cleared to 0.
  - RUN: tick counter counts 0..RATE_DIV-1 and wraps. The tick fires in the cycle the counter equals RATE_DIV-1.
  - Tick with fill_level > 0: pop the head; dac_data ← head; dac_strobe = 1.
  - Tick with fill_level = 0 (underflow): dac_data ← 0 if UNDERFLOW_ZERO, else hold; dac_strobe = 1; underflow_pulse = 1; underflow_count += 1, saturating at 0xFFFF; state → PREFILL.
  - in_enable = 0 in any state → IDLE next cycle. The FIFO contents, dac_data and underflow_count are retained, and no further strobes are issued.
- Simultaneous push and pop: fill_level is unchanged; a push to an empty FIFO on a tick cycle does not satisfy that tick (underflow).
- Pointers wrap modulo DEPTH; occupancy is tracked as an explicit counter, with no full/empty ambiguity.
- Reset mid-operation: everything returns to reset values immediately; FIFO contents are discarded (pointers and level cleared).

## Timing
- Clock edge E0 sets state RUN. The first tick cycle is E0+RATE_DIV-1. dac_data, dac_strobe and underflow_pulse are registered and visible from edge E0+RATE_DIV. After that, strobes recur every RATE_DIV cycles.
- With RATE_DIV = 1, a tick fires every RUN cycle, so dac_strobe stays high continuously.
- Write-to-level latency is 1 cycle. fill_level and running are registered.
- Output latency: a sample at the FIFO head emerges on dac_data 1 cycle after its tick.
- After an underflow, the next strobe comes no earlier than RATE_DIV cycles after PREFILL → RUN.

## Structure
- Shared package cic_pkg holds:
  - typedef enum logic [1:0] pacer_state_e {PACER_IDLE, PACER_PREFILL, PACER_RUN}
  - localparam UFLOW_CNT_W = 16
- Sub-module cic_sync_fifo (parameters DATA_WIDTH, DEPTH) contains storage, read/write pointers and the level counter, and exposes push, pop, head, level, full and empty. The pacer holds the FSM, tick counter and output registers.

## Test plan
- Reset, then push 8 samples 1..8 with in_enable = 1 and defaults → RUN once level = 8; dac_strobe every 4 cycles; dac_data 1,2,…,8 in order.
- Stop pushing after 8 samples → 9th tick underflows: dac_data = 0, underflow_pulse = 1, underflow_count = 1, state PREFILL. Repeat with UNDERFLOW_ZERO = 0 → dac_data holds 8.
- Hold in_enable = 0 and push 20 samples → in_ready drops after 16 accepted; fill_level = 16; no dac_strobe.
- Continuous upstream at full rate with RATE_DIV = 4 for 1000 ticks → no underflow; output sequence equals input sequence; fill_level ≤ 16.
- Force 70000 underflows → underflow_count saturates at 0xFFFF.
- Assert in_reset_n low mid-RUN with level = 5 → all outputs return to reset values asynchronously; fill_level = 0 after release.
